// File: rtl/mult_radix8_seq.sv
// mult_radix8_seq: iterative radix-8 Booth multiplier for RV MUL/MULH/MULHSU/MULHU with valid/ready handshake
module mult_radix8_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] oper_a,
  input  logic [XLEN-1:0] oper_b,
  input  logic [1:0]      op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] mult_o,
  output logic            busy
);
  localparam int NDIG = (XLEN + 3) / 3;
  localparam int BW = 3 * NDIG;
  localparam int AW = 2 * XLEN + 2;
  localparam int CW = $clog2(NDIG);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [XLEN:0]   a_ext, a_in;
  logic [XLEN+2:0] a3;
  logic [BW:0]     b_sh;
  logic [BW-1:0]   b_in;
  logic [1:0]      op_r;
  logic [AW-1:0]   acc, acc_nx, a_w, m, mult;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] res;
  logic [3:0]      d, nd;
  logic [2:0]      mag;
  logic            accept, zero, last;
  assign in_ready  = state == IDLE && !flush;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  assign mult_o    = res;
  assign accept    = in_valid && in_ready;
  assign zero      = oper_a == '0 || oper_b == '0;
  assign last      = cnt == CW'(NDIG - 1);
  assign a_in      = {op != 2'b11 && oper_a[XLEN-1], oper_a};
  assign b_in      = {{(BW-XLEN){!op[1] && oper_b[XLEN-1]}}, oper_b};
  // b_sh holds B_ext with the implicit B_ext[-1]=0 below it; low 4 bits form the current digit
  always_comb begin
    d      = {b_sh[3], b_sh[3:1]} + {3'b000, b_sh[0]};
    nd     = 4'd0 - d;
    mag    = d[3] ? nd[2:0] : d[2:0];
    a_w    = {{(AW-XLEN-1){a_ext[XLEN]}}, a_ext};
    m      = mag == 3'd1 ? a_w :
             mag == 3'd2 ? a_w << 1 :
             mag == 3'd3 ? {{(AW-XLEN-3){a3[XLEN+2]}}, a3} :
             mag == 3'd4 ? a_w << 2 : '0;
    mult   = d[3] ? -m : m;
    acc_nx = acc + (mult << (3 * cnt));
  end
  always_comb begin
    state_nx = flush ? IDLE :
               state == IDLE ? (accept ? (zero ? DONE : CALC) : IDLE) :
               state == CALC ? (last ? DONE : CALC) :
               (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_ext <= '0;
      a3    <= '0;
      b_sh  <= '0;
      op_r  <= '0;
      acc   <= '0;
      cnt   <= '0;
      res   <= '0;
    end else if (accept) begin
      a_ext <= a_in;
      a3    <= {a_in[XLEN], a_in[XLEN], a_in} + {a_in[XLEN], a_in, 1'b0};
      b_sh  <= {b_in, 1'b0};
      op_r  <= op;
      acc   <= '0;
      cnt   <= '0;
      if (zero) res <= '0;
    end else if (state == CALC && !flush) begin
      acc  <= acc_nx;
      cnt  <= cnt + 1'b1;
      b_sh <= b_sh >> 3;
      if (last) res <= op_r == 2'b00 ? acc_nx[XLEN-1:0] : acc_nx[2*XLEN-1:XLEN];
    end
  end
endmodule

// File: tb/tb_mult_radix8_seq.sv
// tb_mult_radix8_seq: randomized and directed checks of mult_radix8_seq against an arithmetic product model
module tb_mult_radix8_seq;
  logic        clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] oper_a = 0, oper_b = 0, mult_o;
  logic [1:0]  op = 0;
  logic        in_ready, out_valid, busy;
  int checks = 0, passed = 0;

  mult_radix8_seq #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .oper_a(oper_a), .oper_b(oper_b), .op(op), .out_valid(out_valid),
    .out_ready(out_ready), .mult_o(mult_o), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(logic [1:0] o, logic [31:0] a, logic [31:0] b);
    logic signed [65:0]  sa, sb;
    logic signed [131:0] p;
    sa = o == 2'b11 ? $signed({34'd0, a}) : $signed({{34{a[31]}}, a});
    sb = o[1] ? $signed({34'd0, b}) : $signed({{34{b[31]}}, b});
    p = sa * sb;
    return o == 2'b00 ? p[31:0] : p[63:32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!in_ready && n < 40) begin tick(); n++; end
    op = o; oper_a = a; oper_b = b; in_valid = 1;
    tick();
    in_valid = 0; oper_a = $urandom; oper_b = $urandom; op = 2'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin tick(); lat++; end
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    start(o, a, b);
    wait_done(lat);
    res = mult_o;
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1; tick(); tick(); rst = 0;
    checks += 4;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    if (mult_o !== 32'h0) $display("FAIL reset_mult_o got %h want 0", mult_o); else passed++;
  endtask

  task automatic test_directed();
    logic [1:0]  ops[5] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
    logic [31:0] as[5]  = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] bs[5]  = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] ex[5]  = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000001};
    logic [31:0] r;
    int lat;
    for (int i = 0; i < 5; i++) begin
      do_op(ops[i], as[i], bs[i], r, lat);
      checks += 2;
      if (r !== ex[i]) $display("FAIL directed%0d_result got %h want %h", i, r, ex[i]); else passed++;
      if (lat !== 12) $display("FAIL directed%0d_latency got %0d want 12", i, lat); else passed++;
    end
  endtask

  task automatic test_zero();
    logic [31:0] r;
    int lat;
    for (int i = 0; i < 2; i++) begin
      do_op(2'b11, i == 0 ? 32'h0 : 32'h12345678, i == 0 ? 32'h12345678 : 32'h0, r, lat);
      checks += 2;
      if (r !== 32'h0) $display("FAIL zero%0d_result got %h want 0", i, r); else passed++;
      if (lat !== 1) $display("FAIL zero%0d_latency got %0d want 1", i, lat); else passed++;
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, r, e;
    logic [1:0]  o;
    int lat;
    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom);
      a = $urandom; b = $urandom;
      if (i % 10 == 3) a = 32'h80000000;
      if (i % 10 == 7) b = 32'hFFFFFFFF;
      if (i % 10 == 9) a = 32'($urandom_range(0, 15));
      e = model(o, a, b);
      do_op(o, a, b, r, lat);
      checks += 2;
      if (r !== e) $display("FAIL random%0d_op%0d a=%h b=%h got %h want %h", i, o, a, b, r, e); else passed++;
      if (lat !== (a == 0 || b == 0 ? 1 : 12)) $display("FAIL random%0d_latency got %0d", i, lat); else passed++;
    end
  endtask

  task automatic test_back_pressure();
    logic [31:0] r;
    int lat, bad;
    start(2'b00, 32'h10000, 32'h10000);
    wait_done(lat);
    checks++;
    if (!out_valid) $display("FAIL bp_valid got %b want 1", out_valid); else passed++;
    bad = 0;
    in_valid = 1;
    for (int i = 0; i < 20; i++) begin
      oper_a = $urandom; oper_b = 32'd3;
      tick();
      if (mult_o !== 32'h0 || busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    in_valid = 0;
    checks++;
    if (bad !== 0) $display("FAIL bp_hold got %0d bad cycles want 0", bad); else passed++;
    out_ready = 1;
    tick();
    out_ready = 0;
    checks += 2;
    if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL bp_release busy=%b valid=%b want 0 0", busy, out_valid); else passed++;
    if (in_ready !== 1'b1) $display("FAIL bp_in_ready got %b want 1", in_ready); else passed++;
    do_op(2'b00, 32'd3, 32'd5, r, lat);
    checks++;
    if (r !== 32'hF) $display("FAIL bp_next got %h want 0000000f", r); else passed++;
  endtask

  task automatic test_flush();
    logic [31:0] r;
    int lat, seen;
    start(2'b01, 32'h1234567, 32'h89ABCDE);
    for (int i = 0; i < 5; i++) tick();
    flush = 1; tick(); flush = 0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL flush_idle busy=%b valid=%b want 0 0", busy, out_valid); else passed++;
    seen = 0;
    for (int i = 0; i < 15; i++) begin tick(); seen += out_valid; end
    checks++;
    if (seen !== 0) $display("FAIL flush_no_valid got %0d want 0", seen); else passed++;
    flush = 1; in_valid = 1; oper_a = 32'd9; oper_b = 32'd9; #1;
    checks++;
    if (in_ready !== 1'b0) $display("FAIL flush_in_ready got %b want 0", in_ready); else passed++;
    tick(); flush = 0; in_valid = 0;
    checks++;
    if (busy !== 1'b0) $display("FAIL flush_block_accept busy got %b want 0", busy); else passed++;
    start(2'b11, 32'hDEADBEEF, 32'hCAFEF00D);
    for (int i = 0; i < 3; i++) tick();
    rst = 1; tick(); rst = 0;
    checks += 4;
    if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b want 1", in_ready); else passed++;
    if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid); else passed++;
    if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else passed++;
    if (mult_o !== 32'h0) $display("FAIL rst_mult_o got %h want 0", mult_o); else passed++;
    seen = 0;
    for (int i = 0; i < 15; i++) begin tick(); seen += out_valid; end
    checks++;
    if (seen !== 0) $display("FAIL rst_no_valid got %0d want 0", seen); else passed++;
    do_op(2'b00, 32'd3, 32'd5, r, lat);
    checks += 2;
    if (r !== 32'hF) $display("FAIL after_rst_result got %h want 0000000f", r); else passed++;
    if (lat !== 12) $display("FAIL after_rst_latency got %0d want 12", lat); else passed++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero();
    test_random();
    test_back_pressure();
    test_flush();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
